stage_mem: RTL and testbench
============================

Name: stage_mem

Overview:
Memory-access pipeline stage. It sits directly after the execute stage and consumes the execute result as an effective address or a pass-through value. It runs RV32 loads and stores over a req/ack data bus, performing byte-lane steering and sign/zero extension. It stalls upstream while a bus access is outstanding and presents a registered writeback result to the WB stage.

Parameters:
DATA_WIDTH, 32, data path width; lane logic supports only 32.
ADDR_WIDTH, 32, bus address width.
REG_WIDTH, 5, destination register index width.

Ports:
i_Clock  in  1  clock
i_Reset  in  1  synchronous, active-low reset
i_Valid  in  1  instruction presented by EX
i_Result  in  DATA_WIDTH  EX result: effective address for mem ops, else the value to write back
i_DataB  in  DATA_WIDTH  store data (rs2)
i_MemOp  in  MemOp  MEM_NONE/LB/LH/LW/LBU/LHU/SB/SH/SW
i_RegWrAddr  in  REG_WIDTH  destination register
o_Stall  out  1  upstream must hold its inputs
o_BusReq  out  1  bus request
o_BusWrEn  out  1  1=write, 0=read
o_BusAddr  out  ADDR_WIDTH  word-aligned address; bits[1:0] forced to 0
o_BusByteEn  out  4  byte-lane enables
o_BusWrData  out  DATA_WIDTH  lane-steered store data
i_BusAck  in  1  access complete; read data valid this cycle
i_BusRdData  in  DATA_WIDTH  read data
o_WbValid  out  1  writeback entry valid (1-cycle pulse per instruction)
o_WbData  out  DATA_WIDTH  writeback value
o_WbRegAddr  out  REG_WIDTH  writeback register
o_Fault  out  1  misaligned access (1-cycle pulse)

Behaviour:
- Reset (i_Reset=0 at an edge): state=IDLE. All outputs 0. Reset wins over every other event; a request in flight is abandoned, o_BusReq drops after that edge, and a late ack is ignored.
- An instruction is consumed on any cycle with i_Valid=1 and o_Stall=0. Upstream holds all inputs while o_Stall=1.
- IDLE, i_Valid, MEM_NONE: no stall. Next cycle o_WbValid=1, o_WbData=i_Result, o_WbRegAddr=i_RegWrAddr.
- IDLE, i_Valid, misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no stall, no bus access. Next cycle o_Fault=1, o_WbValid=0.
- IDLE, i_Valid, aligned mem op: o_Stall=1 combinationally. Latch addr, op, data, lanes and rd. Go to ACCESS.
- ACCESS:
  - o_BusReq=1; addr, wrdata, byteen and wren stay stable until ack.
  - o_Stall = ~i_BusAck. The instruction is consumed in the ack cycle.
  - On ack, go to IDLE. Load: next cycle o_WbValid=1 with the extended data. Store: o_WbValid=0.
- Minimum latency: load 2 cycles from acceptance to o_WbValid (ack in the first ACCESS cycle). Non-mem op: 1 cycle.
- An ack received outside ACCESS is ignored. The bus is never requested back-to-back without an intervening IDLE cycle.
- Lane rules, with off=addr[1:0]:
  - SB: byteen = 0001<<off; wrdata = byte replicated x4.
  - SH: byteen = 0011<<off; wrdata = half replicated x2.
  - SW: byteen = 1111.
  - Loads: byteen = 1111 on the bus. Data = rddata>>(8*off), then LB/LH sign-extend and LBU/LHU zero-extend.
- o_WbValid, o_WbData, o_WbRegAddr and o_Fault are registered. They are 0/held when there is no event.

Decomposition:
- MemOp enum (4-bit) goes in the shared types package beside AluOp, together with the helpers isLoad/isStore.
- The FSM state enum (IDLE, ACCESS) stays local to the module.
- One combinational sub-module, mem_align, handles store lane steering, byteen generation, load extraction/extension and the misalignment check.
- The FSM and registers stay in stage_mem.

Test Plan:
- ALU passthrough: MEM_NONE, Result=0x1234_5678, rd=5 -> no stall; next cycle WbValid=1, WbData=0x12345678, WbRegAddr=5.
- LB sign-extend: addr=0x1003, ack on first ACCESS cycle, rddata=0x80AA_BBCC -> BusAddr=0x1000, Stall high 1 cycle; WbData=0xFFFF_FF80 two cycles after acceptance. LBU same -> 0x0000_0080.
- SH upper half: addr=0x2002, DataB=0x0000_BEEF, ack delayed 3 cycles -> BusReq/WrEn=1, ByteEn=1100, WrData=0xBEEF_BEEF, all held stable; Stall high until ack; WbValid stays 0.
- Misaligned LW: addr=0x3001 -> no BusReq, no stall; Fault=1 for 1 cycle; WbValid=0.
- Reset mid-access: assert i_Reset=0 during ACCESS, then ack arrives after release -> BusReq=0 after reset edge, all outputs 0, late ack ignored, next MEM_NONE proceeds normally.
- Back-to-back: LW 0x4000 (rddata 0xDEADBEEF) followed by MEM_NONE 7 -> WbData 0xDEADBEEF, then 7 on the following cycle; no lost or duplicated WbValid.

Source files
------------

// File: rtl/stage_mem_pkg.sv
// Shared pipeline types: ALU and memory operation encodings, plus helpers
// that classify memory operations as loads or stores.
package stage_mem_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    localparam int BYTE_LANES = 4;

    function automatic logic isLoad(input mem_op_t op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic isStore(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage

// File: rtl/stage_mem_align.sv
// Byte-lane logic for the memory stage: store steering, byte enables,
// alignment check, and load extraction with sign/zero extension.
module mem_align
    import stage_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  mem_op_t                op,
    input  logic [1:0]             addr_off,
    input  logic [DATA_WIDTH-1:0]  store_data,
    output logic [3:0]             byte_en,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   misaligned,
    input  mem_op_t                ld_op,
    input  logic [1:0]             ld_off,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DATA_WIDTH-1:0]  ld_data
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        byte_en    = 4'b0000;
        wr_data    = '0;
        misaligned = 1'b0;
        case (op)
            MEM_LB, MEM_LBU: byte_en = 4'b1111;
            MEM_LH, MEM_LHU: begin
                byte_en    = 4'b1111;
                misaligned = addr_off[0];
            end
            MEM_LW: begin
                byte_en    = 4'b1111;
                misaligned = |addr_off;
            end
            MEM_SB: begin
                byte_en = 4'b0001 << addr_off;
                wr_data = {4{store_data[7:0]}};
            end
            MEM_SH: begin
                byte_en    = 4'b0011 << addr_off;
                wr_data    = {2{store_data[15:0]}};
                misaligned = addr_off[0];
            end
            MEM_SW: begin
                byte_en    = 4'b1111;
                wr_data    = store_data;
                misaligned = |addr_off;
            end
            default: ;
        endcase
    end

    // Loads always fetch the full word; the addressed byte/half is moved down to bit 0.
    assign shifted = rd_data >> {ld_off, 3'b000};

    always_comb begin
        ld_data = '0;
        case (ld_op)
            MEM_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_LBU: ld_data = {24'd0, shifted[7:0]};
            MEM_LH:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_LHU: ld_data = {16'd0, shifted[15:0]};
            MEM_LW:  ld_data = shifted;
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: runs loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding, registers writeback.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 5
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Valid,
    input  logic [DATA_WIDTH-1:0] i_Result,
    input  logic [DATA_WIDTH-1:0] i_DataB,
    input  mem_op_t               i_MemOp,
    input  logic [REG_WIDTH-1:0]  i_RegWrAddr,
    output logic                  o_Stall,
    output logic                  o_BusReq,
    output logic                  o_BusWrEn,
    output logic [ADDR_WIDTH-1:0] o_BusAddr,
    output logic [3:0]            o_BusByteEn,
    output logic [DATA_WIDTH-1:0] o_BusWrData,
    input  logic                  i_BusAck,
    input  logic [DATA_WIDTH-1:0] i_BusRdData,
    output logic                  o_WbValid,
    output logic [DATA_WIDTH-1:0] o_WbData,
    output logic [REG_WIDTH-1:0]  o_WbRegAddr,
    output logic                  o_Fault
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wrdata_q;
    logic [3:0]            byteen_q;
    mem_op_t               op_q;
    logic [REG_WIDTH-1:0]  rd_q;
    logic                  wren_q;

    logic [3:0]            byte_en_in;
    logic [DATA_WIDTH-1:0] wr_data_in;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  misaligned;
    logic                  is_mem;
    logic                  in_access;

    mem_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .op         (i_MemOp),
        .addr_off   (i_Result[1:0]),
        .store_data (i_DataB),
        .byte_en    (byte_en_in),
        .wr_data    (wr_data_in),
        .misaligned (misaligned),
        .ld_op      (op_q),
        .ld_off     (addr_q[1:0]),
        .rd_data    (i_BusRdData),
        .ld_data    (ld_data)
    );

    assign is_mem    = isLoad(i_MemOp) || isStore(i_MemOp);
    assign in_access = (state == ST_ACCESS);

    // Stall is held low while reset is asserted so every output reads 0 in reset.
    always_comb begin
        o_Stall = 1'b0;
        if (i_Reset) begin
            if (in_access)
                o_Stall = ~i_BusAck;
            else
                o_Stall = i_Valid && is_mem && !misaligned;
        end
    end

    assign o_BusReq    = in_access;
    assign o_BusWrEn   = in_access && wren_q;
    assign o_BusAddr   = in_access ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign o_BusByteEn = in_access ? byteen_q : 4'b0000;
    assign o_BusWrData = in_access ? wrdata_q : '0;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            wrdata_q    <= '0;
            byteen_q    <= 4'b0000;
            op_q        <= MEM_NONE;
            rd_q        <= '0;
            wren_q      <= 1'b0;
            o_WbValid   <= 1'b0;
            o_WbData    <= '0;
            o_WbRegAddr <= '0;
            o_Fault     <= 1'b0;
        end else begin
            o_WbValid <= 1'b0;
            o_Fault   <= 1'b0;
            if (state == ST_IDLE) begin
                if (i_Valid) begin
                    if (!is_mem) begin
                        o_WbValid   <= 1'b1;
                        o_WbData    <= i_Result;
                        o_WbRegAddr <= i_RegWrAddr;
                    end else if (misaligned) begin
                        o_Fault <= 1'b1;
                    end else begin
                        addr_q   <= i_Result[ADDR_WIDTH-1:0];
                        wrdata_q <= wr_data_in;
                        byteen_q <= byte_en_in;
                        op_q     <= i_MemOp;
                        rd_q     <= i_RegWrAddr;
                        wren_q   <= isStore(i_MemOp);
                        state    <= ST_ACCESS;
                    end
                end
            end else if (i_BusAck) begin
                // Returning to IDLE here guarantees an idle bus cycle between accesses.
                state <= ST_IDLE;
                if (!wren_q) begin
                    o_WbValid   <= 1'b1;
                    o_WbData    <= ld_data;
                    o_WbRegAddr <= rd_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: table-driven vectors with a writeback
// scoreboard, plus a hand-written reset-during-access sequence.
module tb_stage_mem;
    import stage_mem_pkg::*;

    logic        clk;
    logic        i_Reset;
    logic        i_Valid;
    logic [31:0] i_Result;
    logic [31:0] i_DataB;
    mem_op_t     i_MemOp;
    logic [4:0]  i_RegWrAddr;
    logic        o_Stall;
    logic        o_BusReq;
    logic        o_BusWrEn;
    logic [31:0] o_BusAddr;
    logic [3:0]  o_BusByteEn;
    logic [31:0] o_BusWrData;
    logic        i_BusAck;
    logic [31:0] i_BusRdData;
    logic        o_WbValid;
    logic [31:0] o_WbData;
    logic [4:0]  o_WbRegAddr;
    logic        o_Fault;

    stage_mem dut (
        .i_Clock     (clk),
        .i_Reset     (i_Reset),
        .i_Valid     (i_Valid),
        .i_Result    (i_Result),
        .i_DataB     (i_DataB),
        .i_MemOp     (i_MemOp),
        .i_RegWrAddr (i_RegWrAddr),
        .o_Stall     (o_Stall),
        .o_BusReq    (o_BusReq),
        .o_BusWrEn   (o_BusWrEn),
        .o_BusAddr   (o_BusAddr),
        .o_BusByteEn (o_BusByteEn),
        .o_BusWrData (o_BusWrData),
        .i_BusAck    (i_BusAck),
        .i_BusRdData (i_BusRdData),
        .o_WbValid   (o_WbValid),
        .o_WbData    (o_WbData),
        .o_WbRegAddr (o_WbRegAddr),
        .o_Fault     (o_Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        mem_op_t     op;
        logic [31:0] result;
        logic [31:0] datab;
        logic [4:0]  rd;
        logic [31:0] rddata;
        int          delay;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wrdata;
        bit          exp_wb;
        logic [31:0] exp_data;
        bit          exp_fault;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_t;

    vec_t vec[15];
    wb_t  sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   fault_seen = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Writeback monitor: every WbValid pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #2;
        if (i_Reset && o_WbValid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL wb_unexpected: got data 0x%08h rd %0d with nothing expected at %0t",
                         o_WbData, o_WbRegAddr, $time);
            end else begin
                wb_t e;
                e = sb.pop_front();
                checkOutput("wb_data", o_WbData, e.data);
                checkOutput("wb_reg", {27'd0, o_WbRegAddr}, {27'd0, e.rd});
            end
        end
        if (o_Fault)
            fault_seen++;
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic applyStimulus(input int idx);
        vec_t v;
        bit   is_store;
        v = vec[idx];
        is_store = (v.op == MEM_SB) || (v.op == MEM_SH) || (v.op == MEM_SW);
        i_Valid     = 1'b1;
        i_MemOp     = v.op;
        i_Result    = v.result;
        i_DataB     = v.datab;
        i_RegWrAddr = v.rd;
        if (v.op == MEM_NONE || v.exp_fault) begin
            if (v.exp_wb)
                sb.push_back('{v.result, v.rd});
            #1;
            checkOutput("stall_nomem", {31'd0, o_Stall}, 32'd0);
            checkOutput("busreq_nomem", {31'd0, o_BusReq}, 32'd0);
            @(posedge clk);
            #1;
            i_Valid = 1'b0;
            checkOutput("fault", {31'd0, o_Fault}, {31'd0, v.exp_fault});
        end else begin
            #1;
            checkOutput("stall_accept", {31'd0, o_Stall}, 32'd1);
            checkOutput("busreq_idle", {31'd0, o_BusReq}, 32'd0);
            @(posedge clk);
            #1;
            for (int c = 0; c < v.delay; c++) begin
                i_BusRdData = $urandom;
                #1;
                checkOutput("busreq", {31'd0, o_BusReq}, 32'd1);
                checkOutput("buswren", {31'd0, o_BusWrEn}, {31'd0, is_store});
                checkOutput("busaddr", o_BusAddr, v.exp_addr);
                checkOutput("busbe", {28'd0, o_BusByteEn}, {28'd0, v.exp_be});
                if (is_store)
                    checkOutput("buswrdata", o_BusWrData, v.exp_wrdata);
                checkOutput("stall_wait", {31'd0, o_Stall}, 32'd1);
                @(posedge clk);
                #1;
            end
            i_BusAck    = 1'b1;
            i_BusRdData = v.rddata;
            if (v.exp_wb)
                sb.push_back('{v.exp_data, v.rd});
            #1;
            checkOutput("busreq_ack", {31'd0, o_BusReq}, 32'd1);
            checkOutput("busaddr_ack", o_BusAddr, v.exp_addr);
            checkOutput("busbe_ack", {28'd0, o_BusByteEn}, {28'd0, v.exp_be});
            if (is_store)
                checkOutput("buswrdata_ack", o_BusWrData, v.exp_wrdata);
            checkOutput("stall_ack", {31'd0, o_Stall}, 32'd0);
            @(posedge clk);
            #1;
            i_BusAck = 1'b0;
            i_Valid  = 1'b0;
            checkOutput("busreq_gap", {31'd0, o_BusReq}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //               op        result        datab         rd     rddata        dly addr          be       wrdata        wb  data          fault
        vec[0]  = '{MEM_NONE, 32'h1234_5678, 32'h0,         5'd5,  32'h0,         0, 32'h0,        4'h0, 32'h0,         1, 32'h1234_5678, 0};
        vec[1]  = '{MEM_LB,   32'h0000_1003, 32'h0,         5'd6,  32'h80AA_BBCC, 0, 32'h0000_1000, 4'hF, 32'h0,        1, 32'hFFFF_FF80, 0};
        vec[2]  = '{MEM_LBU,  32'h0000_1003, 32'h0,         5'd7,  32'h80AA_BBCC, 0, 32'h0000_1000, 4'hF, 32'h0,        1, 32'h0000_0080, 0};
        vec[3]  = '{MEM_SH,   32'h0000_2002, 32'h0000_BEEF, 5'd0,  32'h0,         3, 32'h0000_2000, 4'hC, 32'hBEEF_BEEF, 0, 32'h0,        0};
        vec[4]  = '{MEM_LW,   32'h0000_3001, 32'h0,         5'd8,  32'h0,         0, 32'h0,        4'h0, 32'h0,         0, 32'h0,         1};
        vec[5]  = '{MEM_LW,   32'h0000_4000, 32'h0,         5'd8,  32'hDEAD_BEEF, 0, 32'h0000_4000, 4'hF, 32'h0,        1, 32'hDEAD_BEEF, 0};
        vec[6]  = '{MEM_NONE, 32'h0000_0007, 32'h0,         5'd9,  32'h0,         0, 32'h0,        4'h0, 32'h0,         1, 32'h0000_0007, 0};
        vec[7]  = '{MEM_SB,   32'h0000_6001, 32'h1234_56A5, 5'd0,  32'h0,         1, 32'h0000_6000, 4'h2, 32'hA5A5_A5A5, 0, 32'h0,        0};
        vec[8]  = '{MEM_LH,   32'h0000_7002, 32'h0,         5'd10, 32'h8001_1234, 0, 32'h0000_7000, 4'hF, 32'h0,        1, 32'hFFFF_8001, 0};
        vec[9]  = '{MEM_LHU,  32'h0000_7000, 32'h0,         5'd11, 32'h8001_F234, 2, 32'h0000_7000, 4'hF, 32'h0,        1, 32'h0000_F234, 0};
        vec[10] = '{MEM_SW,   32'h0000_8000, 32'hCAFE_F00D, 5'd0,  32'h0,         2, 32'h0000_8000, 4'hF, 32'hCAFE_F00D, 0, 32'h0,        0};
        vec[11] = '{MEM_SH,   32'h0000_9003, 32'h0000_1111, 5'd0,  32'h0,         0, 32'h0,        4'h0, 32'h0,         0, 32'h0,         1};
        vec[12] = '{MEM_LHU,  32'h0000_9001, 32'h0,         5'd12, 32'h0,         0, 32'h0,        4'h0, 32'h0,         0, 32'h0,         1};
        vec[13] = '{MEM_LB,   32'h0000_B001, 32'h0,         5'd13, 32'h1234_7F00, 1, 32'h0000_B000, 4'hF, 32'h0,        1, 32'h0000_007F, 0};
        vec[14] = '{MEM_NONE, 32'hA5A5_0001, 32'h0,         5'd31, 32'h0,         0, 32'h0,        4'h0, 32'h0,         1, 32'hA5A5_0001, 0};

        i_Reset     = 1'b0;
        i_Valid     = 1'b0;
        i_Result    = 32'h0;
        i_DataB     = 32'h0;
        i_MemOp     = MEM_NONE;
        i_RegWrAddr = 5'd0;
        i_BusAck    = 1'b0;
        i_BusRdData = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busreq", {31'd0, o_BusReq}, 32'd0);
        checkOutput("rst_stall", {31'd0, o_Stall}, 32'd0);
        checkOutput("rst_wbvalid", {31'd0, o_WbValid}, 32'd0);
        checkOutput("rst_wbdata", o_WbData, 32'd0);
        checkOutput("rst_fault", {31'd0, o_Fault}, 32'd0);
        i_Reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++)
            applyStimulus(i);

        // Reset during an outstanding load, then a late ack that must be ignored.
        i_Valid     = 1'b1;
        i_MemOp     = MEM_LW;
        i_Result    = 32'h0000_5004;
        i_RegWrAddr = 5'd14;
        #1;
        checkOutput("rstseq_stall", {31'd0, o_Stall}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rstseq_busreq", {31'd0, o_BusReq}, 32'd1);
        i_Reset = 1'b0;
        i_Valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstseq_busreq_drop", {31'd0, o_BusReq}, 32'd0);
        checkOutput("rstseq_busaddr", o_BusAddr, 32'd0);
        checkOutput("rstseq_busbe", {28'd0, o_BusByteEn}, 32'd0);
        checkOutput("rstseq_stall_rst", {31'd0, o_Stall}, 32'd0);
        checkOutput("rstseq_wbvalid", {31'd0, o_WbValid}, 32'd0);
        checkOutput("rstseq_wbdata", o_WbData, 32'd0);
        checkOutput("rstseq_wbreg", {27'd0, o_WbRegAddr}, 32'd0);
        i_Reset     = 1'b1;
        i_BusAck    = 1'b1;
        i_BusRdData = 32'h1111_1111;
        #1;
        checkOutput("rstseq_late_ack_stall", {31'd0, o_Stall}, 32'd0);
        @(posedge clk);
        #1;
        i_BusAck = 1'b0;
        checkOutput("rstseq_late_ack_busreq", {31'd0, o_BusReq}, 32'd0);
        checkOutput("rstseq_late_ack_wb", {31'd0, o_WbValid}, 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(14);
        repeat (3) @(posedge clk);
        #3;

        checkOutput("sb_drained", sb.size(), 32'd0);
        checkOutput("fault_count", fault_seen, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
